// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the nibble adder datapath and its result FIFO.
//   SUM_W      : width of one adder result (4-bit sum plus carry in bit 4)
//   sum_t      : adder result type
//   DROP_CNT_W : width of the saturating dropped-result counter
//   sat_inc()  : saturating increment used by the drop counter
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int SUM_W      = 5;
    localparam int DROP_CNT_W = 8;

    typedef logic [SUM_W-1:0] sum_t;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/result_fifo_mem.sv
// -----------------------------------------------------------------------------
// result_fifo_mem
// DEPTH x DATA_W register array backing the adder result FIFO.
// Storage is deliberately not reset; only the pointers/count in the parent
// carry reset state.
// Ports:
//   clk    in   clock, write on rising edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  asynchronous read data (mem[raddr])
// -----------------------------------------------------------------------------
module result_fifo_mem #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 5
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/adder_result_fifo.sv
// -----------------------------------------------------------------------------
// adder_result_fifo
// Captures each 5-bit adder result on in_valid into a small show-ahead FIFO
// and hands it to a consumer through a valid/ready handshake. When the FIFO
// is full and the consumer does not pop, the incoming result is dropped.
//
// Build option: define ADDER_RESULT_FIFO_OVF_EN to build the sticky overflow
// flag and the saturating drop counter (cleared by ovf_clear). Without it,
// overflow and drop_cnt are tied to 0 and ovf_clear is ignored; drops still
// discard data silently.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high reset
//   in_data    in   result from the adder stage
//   in_valid   in   in_data is a new result this cycle
//   out_data   out  head entry (show-ahead), meaningful while out_valid
//   out_valid  out  FIFO non-empty
//   out_ready  in   consumer takes the head entry this cycle
//   count      out  occupancy, 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0
//   overflow   out  sticky: at least one result was dropped
//   ovf_clear  in   synchronous clear of overflow and drop_cnt
//   drop_cnt   out  saturating count of dropped results
// -----------------------------------------------------------------------------
module adder_result_fifo
    import adder_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = SUM_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow,
    input  logic                    ovf_clear,
    output logic [DROP_CNT_W-1:0]   drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_r;
    logic          push;
    logic          pop;

    // Status is decoded from the occupancy register only, so in_valid and
    // out_ready never reach these outputs combinationally.
    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == '0);
    assign out_valid = !empty;
    assign count     = count_r;

    assign pop  = out_valid & out_ready;
    // A full FIFO still accepts a result when the head leaves in the same cycle.
    assign push = in_valid & (!full | pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    result_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

`ifdef ADDER_RESULT_FIFO_OVF_EN
    logic                  drop;
    logic                  ovf_r;
    logic [DROP_CNT_W-1:0] drop_r;

    assign drop = in_valid & full & !pop;

    // ovf_clear wins over a drop in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_r  <= 1'b0;
            drop_r <= '0;
        end else if (ovf_clear) begin
            ovf_r  <= 1'b0;
            drop_r <= '0;
        end else if (drop) begin
            ovf_r  <= 1'b1;
            drop_r <= sat_inc(drop_r);
        end
    end

    assign overflow = ovf_r;
    assign drop_cnt = drop_r;
`else
    logic unused_ovf_clear;

    assign unused_ovf_clear = ovf_clear;
    assign overflow         = 1'b0;
    assign drop_cnt         = '0;
`endif

endmodule

// File: tb/tb_adder_result_fifo.sv
module tb_adder_result_fifo;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 5;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              ovf_clear;
    logic [7:0]        drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: FIFO contents as a plain queue, plus overflow state.
    logic [DATA_W-1:0] exp_q [$];
    int                m_drop = 0;
    bit                m_ovf  = 0;

    adder_result_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .ovf_clear (ovf_clear),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: whenever the DUT offers a head entry that the consumer takes,
    // it must be the oldest accepted result.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_underflow: DUT popped 0x%0h, model queue empty at %0t", out_data, $time);
            end else begin
                if (out_data !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL pop_data: got 0x%0h, expected 0x%0h at %0t", out_data, exp_q[0], $time);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic check_state();
        int occ;
        occ = exp_q.size();
        chk("count", int'(count), occ);
        chk("empty", int'(empty), int'(occ == 0));
        chk("full", int'(full), int'(occ == DEPTH));
        chk("out_valid", int'(out_valid), int'(occ > 0));
        if (occ > 0) chk("head_data", int'(out_data), int'(exp_q[0]));
`ifdef ADDER_RESULT_FIFO_OVF_EN
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("drop_cnt", int'(drop_cnt), m_drop);
`else
        chk("overflow", int'(overflow), 0);
        chk("drop_cnt", int'(drop_cnt), 0);
`endif
    endtask

    // One clock of stimulus: check state left by the previous edge, then
    // drive this cycle's inputs and record what the FIFO should do with them.
    task automatic step(input bit iv, input logic [DATA_W-1:0] d, input bit rdy, input bit clr = 1'b0);
        bit pop_m;
        bit full_m;
        @(posedge clk);
        #2;
        check_state();
        in_valid  = iv;
        in_data   = d;
        out_ready = rdy;
        ovf_clear = clr;
        pop_m  = (exp_q.size() > 0) && rdy;
        full_m = (exp_q.size() == DEPTH);
        if (iv && (!full_m || pop_m)) begin
            exp_q.push_back(d);
        end else if (iv) begin
            m_ovf  = 1'b1;
            m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end
        if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        ovf_clear = 1'b0;
        #22;
        reset = 1'b0;

        // Reset state, then three pushes held at the output.
        step(1, 5'h1F, 0);
        step(1, 5'h00, 0);
        step(1, 5'h0A, 0);
        step(0, 5'h00, 0);
        chk("tp1_count", int'(count), 3);
        chk("tp1_head", int'(out_data), 'h1F);
        for (int i = 0; i < 4; i++) step(0, 5'h00, 1);

        // Fill 1..4 and drain, three times for pointer wrap.
        for (int r = 0; r < 3; r++) begin
            for (int i = 1; i <= 4; i++) step(1, DATA_W'(i), 0);
            for (int i = 0; i < 4; i++) step(0, 5'h00, 1);
            step(0, 5'h00, 0);
            chk("wrap_empty", int'(empty), 1);
        end

        // Full with simultaneous push and pop.
        for (int i = 6; i <= 9; i++) step(1, DATA_W'(i), 0);
        step(1, 5'h15, 1);
        step(0, 5'h00, 0);
        chk("fullpp_count", int'(count), 4);
        for (int i = 0; i < 4; i++) step(0, 5'h00, 1);

        // Long overflow run with the consumer stalled, then clear (clear
        // coincides with another drop, which must lose).
        for (int i = 0; i < 4; i++) step(1, DATA_W'(5'h10 + i), 0);
        for (int i = 0; i < 300; i++) step(1, DATA_W'($urandom), 0);
        step(1, 5'h1E, 0, 1);
        step(0, 5'h00, 0);
        for (int i = 0; i < 4; i++) step(0, 5'h00, 1);

        // Streaming: push every cycle, pop every cycle.
        for (int i = 0; i < 20; i++) step(1, DATA_W'(i + 3), 1);
        step(0, 5'h00, 1);
        step(0, 5'h00, 0);

        // Asynchronous reset in the middle of a stream with three entries.
        step(1, 5'h04, 0);
        step(1, 5'h05, 0);
        step(1, 5'h06, 0);
        @(posedge clk);
        #2;
        chk("pre_rst_count", int'(count), 3);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        exp_q.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        #3;
        reset = 1'b0;
        step(1, 5'h0C, 0);
        step(0, 5'h00, 0);
        chk("post_rst_head", int'(out_data), 'h0C);
        step(0, 5'h00, 1);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), DATA_W'($urandom), bit'($urandom_range(0, 2) == 0),
                 bit'($urandom_range(0, 40) == 0));
        end
        for (int i = 0; i < 6; i++) step(0, 5'h00, 1);
        step(0, 5'h00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
